// File: rtl/qei_readout_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qei_readout_arbiter
// Brief    : Round-robin arbiter that snapshots a shared QEI count/direction
//            and serializes it as LO, HI, STAT bytes over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module qei_readout_arbiter #(
    parameter int CNT_W = 16,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             dir_in,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  rdclr,
    input  logic             byte_ready,
    output logic [NREQ-1:0]  gnt,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic             byte_last,
    output logic             busy,
    output logic             cnt_clr
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SEND_LO = 3'd1;
    localparam logic [2:0] c_ST_SEND_HI = 3'd2;
    localparam logic [2:0] c_ST_SEND_ST = 3'd3;
    localparam logic [2:0] c_ST_GAP     = 3'd4;

    logic [2:0]         r_state;
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [c_PTR_W-1:0] r_winner;
    logic [7:0]         r_snap_hi;
    logic               r_snap_dir;
    logic               r_snap_clr;
    logic [NREQ-1:0]    r_gnt;
    logic [7:0]         r_byte_out;
    logic               r_byte_valid;
    logic               r_byte_last;
    logic               r_cnt_clr;

    logic               w_found;
    logic [c_PTR_W:0]   w_idx;
    logic [c_PTR_W-1:0] w_win;
    logic [c_PTR_W:0]   w_next_sum;
    logic [c_PTR_W-1:0] w_next_ptr;
    logic [15:0]        w_cnt_zext;
    logic               w_end_xfer;

    assign w_cnt_zext = 16'(cnt_in);

    // Scan requesters starting at the round-robin pointer, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (c_PTR_W + 1)'(i);
            if (w_idx >= (c_PTR_W + 1)'(NREQ)) begin
                w_idx = w_idx - (c_PTR_W + 1)'(NREQ);
            end
            if (!w_found && req[w_idx[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_PTR_W-1:0];
            end
        end
    end

    assign w_next_sum = {1'b0, r_winner} + (c_PTR_W + 1)'(1);
    assign w_next_ptr = (w_next_sum >= (c_PTR_W + 1)'(NREQ)) ? '0 : w_next_sum[c_PTR_W-1:0];

    // Completion of STAT takes precedence over a simultaneous request drop.
    assign w_end_xfer = ((r_state == c_ST_SEND_ST) && byte_ready) || !req[r_winner];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_rr_ptr     <= '0;
            r_winner     <= '0;
            r_snap_hi    <= '0;
            r_snap_dir   <= 1'b0;
            r_snap_clr   <= 1'b0;
            r_gnt        <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_byte_last  <= 1'b0;
            r_cnt_clr    <= 1'b0;
        end else begin
            r_cnt_clr <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_gnt        <= NREQ'(1'b1) << w_win;
                        r_winner     <= w_win;
                        r_snap_hi    <= w_cnt_zext[15:8];
                        r_snap_dir   <= dir_in;
                        r_snap_clr   <= rdclr[w_win];
                        r_cnt_clr    <= rdclr[w_win];
                        r_byte_valid <= 1'b1;
                        r_byte_out   <= w_cnt_zext[7:0];
                        r_state      <= c_ST_SEND_LO;
                    end
                end
                c_ST_SEND_LO, c_ST_SEND_HI, c_ST_SEND_ST: begin
                    if (w_end_xfer) begin
                        r_gnt        <= '0;
                        r_byte_valid <= 1'b0;
                        r_byte_last  <= 1'b0;
                        r_rr_ptr     <= w_next_ptr;
                        r_state      <= c_ST_GAP;
                    end else if (byte_ready) begin
                        if (r_state == c_ST_SEND_LO) begin
                            r_byte_out <= r_snap_hi;
                            r_state    <= c_ST_SEND_HI;
                        end else if (r_state == c_ST_SEND_HI) begin
                            r_byte_out  <= {r_snap_dir, 6'b0, r_snap_clr};
                            r_byte_last <= 1'b1;
                            r_state     <= c_ST_SEND_ST;
                        end
                    end
                end
                c_ST_GAP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign byte_last  = r_byte_last;
    assign cnt_clr    = r_cnt_clr;
    assign busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
